// File: rtl/vga_pkg.sv
// Shared 640x480 raster timing and the state set of the sync-to-counter tracker.
package vga_pkg;
  localparam int   TOTAL_COLS   = 800;
  localparam int   ACTIVE_COLS  = 640;
  localparam int   TOTAL_ROWS   = 525;
  localparam int   ACTIVE_ROWS  = 480;
  localparam int   H_SYNC_START = 656;
  localparam int   V_SYNC_START = 490;
  localparam logic SYNC_ACTIVE  = 1'b0;
  localparam int   LOCK_FRAMES  = 2;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} sync_state_t;
endpackage

// File: rtl/sync_to_count_if.sv
// Sync inputs and rebuilt raster outputs of sync_to_count, bundled as one port.
interface sync_to_count_if import vga_pkg::*; #(
  parameter int ROW_W = $clog2(TOTAL_ROWS),
  parameter int COL_W = $clog2(TOTAL_COLS)
);
  logic             hsync;
  logic             vsync;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             active;
  logic             locked;
  logic             frame_start;
  logic             sync_err;

  modport master (output hsync, vsync,
                  input  row, col, active, locked, frame_start, sync_err);
  modport slave  (input  hsync, vsync,
                  output row, col, active, locked, frame_start, sync_err);
endinterface

// File: rtl/sync_edge_detect.sv
// Two-stage sync input register with a one-cycle pulse on the assertion edge.
module sync_edge_detect #(
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync,
  output logic asserted
);
  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= ~SYNC_ACTIVE;
      s2 <= ~SYNC_ACTIVE;
    end else begin
      s1 <= sync;
      s2 <= s1;
    end
  end

  assign asserted = (s1 == SYNC_ACTIVE) && (s2 != SYNC_ACTIVE);
endmodule

// File: rtl/sync_to_count.sv
// Rebuilds row/col counters from an hsync/vsync pair and tracks lock by checking
// every sync edge against the free-running prediction.
module sync_to_count #(
  parameter int   TOTAL_COLS   = vga_pkg::TOTAL_COLS,
  parameter int   ACTIVE_COLS  = vga_pkg::ACTIVE_COLS,
  parameter int   TOTAL_ROWS   = vga_pkg::TOTAL_ROWS,
  parameter int   ACTIVE_ROWS  = vga_pkg::ACTIVE_ROWS,
  parameter int   H_SYNC_START = vga_pkg::H_SYNC_START,
  parameter int   V_SYNC_START = vga_pkg::V_SYNC_START,
  parameter logic SYNC_ACTIVE  = vga_pkg::SYNC_ACTIVE,
  parameter int   LOCK_FRAMES  = vga_pkg::LOCK_FRAMES
) (
  input  logic            clk,
  input  logic            RESET,
  sync_to_count_if.slave  bus
);
  import vga_pkg::*;

  localparam int ROW_W = $clog2(TOTAL_ROWS);
  localparam int COL_W = $clog2(TOTAL_COLS);
  localparam int WD_W  = $clog2(2*TOTAL_COLS);
  localparam int CNT_W = $clog2(LOCK_FRAMES+1);

  sync_state_t      state, state_next;
  logic [ROW_W-1:0] row, row_pred, row_next;
  logic [COL_W-1:0] col, col_pred, col_next;
  logic [WD_W-1:0]  wd, wd_next;
  logic [CNT_W-1:0] clean, clean_next;
  logic             seen_h, seen_h_next;
  logic             sync_err, sync_err_next;
  logic             h_edge, v_edge, h_match, v_match, mismatch, wd_expired;

  sync_edge_detect #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_h_edge (
    .clk(clk), .rst_n(RESET), .sync(bus.hsync), .asserted(h_edge)
  );

  sync_edge_detect #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_v_edge (
    .clk(clk), .rst_n(RESET), .sync(bus.vsync), .asserted(v_edge)
  );

  // Loads always win, so a vsync edge on a line wrap lands on V_SYNC_START.
  always_comb begin
    col_pred = (col == COL_W'(TOTAL_COLS-1)) ? '0 : col + 1'b1;
    row_pred = row;
    if (col == COL_W'(TOTAL_COLS-1))
      row_pred = (row == ROW_W'(TOTAL_ROWS-1)) ? '0 : row + 1'b1;
    h_match  = (col_pred == COL_W'(H_SYNC_START));
    v_match  = (row_pred == ROW_W'(V_SYNC_START));
    col_next = h_edge ? COL_W'(H_SYNC_START) : col_pred;
    row_next = v_edge ? ROW_W'(V_SYNC_START) : row_pred;
  end

  always_comb begin
    state_next    = state;
    clean_next    = clean;
    seen_h_next   = seen_h | h_edge;
    sync_err_next = 1'b0;
    mismatch      = (h_edge && !h_match) || (v_edge && !v_match);
    wd_expired    = !h_edge && (wd == WD_W'(2*TOTAL_COLS-1));
    wd_next       = (h_edge || wd_expired) ? '0 : wd + 1'b1;
    // Losing hsync entirely trumps everything else and forces a fresh search.
    if (wd_expired) begin
      state_next  = SEARCH;
      clean_next  = '0;
      seen_h_next = 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (v_edge && seen_h) begin
            state_next = ACQUIRE;
            clean_next = '0;
          end
        end
        ACQUIRE: begin
          if (mismatch) begin
            clean_next = '0;
          end else if (v_edge) begin
            clean_next = clean + 1'b1;
            if (int'(clean) + 1 == LOCK_FRAMES)
              state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            sync_err_next = 1'b1;
            state_next    = ACQUIRE;
            clean_next    = '0;
          end
        end
        default: state_next = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state    <= SEARCH;
      row      <= '0;
      col      <= '0;
      wd       <= '0;
      clean    <= '0;
      seen_h   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_next;
      row      <= row_next;
      col      <= col_next;
      wd       <= wd_next;
      clean    <= clean_next;
      seen_h   <= seen_h_next;
      sync_err <= sync_err_next;
    end
  end

  assign bus.row         = row;
  assign bus.col         = col;
  assign bus.locked      = (state == LOCKED);
  assign bus.active      = (state == LOCKED) && (row < ROW_W'(ACTIVE_ROWS)) && (col < COL_W'(ACTIVE_COLS));
  assign bus.frame_start = (state == LOCKED) && (row == '0) && (col == '0);
  assign bus.sync_err    = sync_err;
endmodule

// File: tb/tb_sync_to_count.sv
// Bench for sync_to_count: a scaled-down raster generator feeds the tracker and a
// delayed-position scoreboard checks the rebuilt counters while locked.
module tb_sync_to_count;
  import vga_pkg::*;

  localparam int TC = 40, AC = 32, TR = 20, AR = 16;
  localparam int HS = 33, HW = 4, VS = 17, VW = 2, LF = 2;
  localparam int FRAME = TC*TR;
  localparam int ROW_W = $clog2(TR), COL_W = $clog2(TC);

  logic clk = 1'b0;
  logic RESET = 1'b0;
  always #5 clk = ~clk;

  sync_to_count_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  sync_to_count #(
    .TOTAL_COLS(TC), .ACTIVE_COLS(AC), .TOTAL_ROWS(TR), .ACTIVE_ROWS(AR),
    .H_SYNC_START(HS), .V_SYNC_START(VS), .SYNC_ACTIVE(1'b0), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .RESET(RESET), .bus(bus)
  );

  int total = 0, bad = 0;
  int gcol = 0, grow = 0, cyc = 0;
  int shift_row = -1, drop_row = -1;
  bit hold_h = 1'b0;
  int h_start;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gcol == TC-1) begin
      gcol <= 0;
      grow <= (grow == TR-1) ? 0 : grow + 1;
    end else begin
      gcol <= gcol + 1;
    end
  end

  always_comb begin
    h_start   = (grow == shift_row) ? HS + 3 : HS;
    bus.hsync = !(gcol >= h_start && gcol < h_start + HW && grow != drop_row && !hold_h);
    bus.vsync = !(grow >= VS && grow < VS + VW);
  end

  typedef struct {int r; int c;} pos_t;
  pos_t exp_q[$];
  bit track_en = 1'b0;
  int track_n = 0, track_bad = 0;
  int err_pulses = 0, fs_pulses = 0, fs_prev = 0, fs_last = 0;
  int active_cycles = 0, unlocked_active = 0;

  // Generator position goes in each cycle; the tracker must show it two cycles later.
  always @(negedge clk) begin
    pos_t np, p;
    np.r = grow;
    np.c = gcol;
    exp_q.push_back(np);
    if (exp_q.size() > 2) begin
      p = exp_q.pop_front();
      if (track_en && bus.locked === 1'b1) begin
        track_n++;
        if (bus.row !== ROW_W'(p.r) || bus.col !== COL_W'(p.c)) track_bad++;
      end
    end
    if (bus.sync_err === 1'b1) err_pulses++;
    if (bus.frame_start === 1'b1) begin
      fs_pulses++;
      fs_prev = fs_last;
      fs_last = cyc;
    end
    if (bus.active === 1'b1) active_cycles++;
    if (bus.active === 1'b1 && bus.locked !== 1'b1) unlocked_active++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_gen(input int r, input int c);
    for (int i = 0; i < 2*FRAME; i++) begin
      step(1);
      if ((r < 0 || grow == r) && gcol == c) break;
    end
  endtask

  task automatic wait_lock(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (bus.locked === 1'b1) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    step(4);
    total++;
    if (bus.row !== '0 || bus.col !== '0) begin
      bad++;
      $display("[TB] FAIL reset_counters: row=%0d col=%0d want 0 0", bus.row, bus.col);
    end
    total++;
    if ({bus.active, bus.locked, bus.frame_start, bus.sync_err} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b want 0000",
               {bus.active, bus.locked, bus.frame_start, bus.sync_err});
    end
  endtask

  task automatic test_clean_lock();
    int t0, t_lock;
    wait_gen(0, 0);
    t0 = cyc;
    wait_gen(0, 5);
    unlocked_active = 0;
    RESET = 1'b1;
    wait_lock(4*FRAME, t_lock);
    total++;
    if (t_lock !== t0 + 2*FRAME + VS*TC + 2) begin
      bad++;
      $display("[TB] FAIL lock_time: got cycle %0d want %0d", t_lock, t0 + 2*FRAME + VS*TC + 2);
    end
    total++;
    if (unlocked_active !== 0) begin
      bad++;
      $display("[TB] FAIL active_before_lock: got %0d cycles want 0", unlocked_active);
    end
  endtask

  task automatic test_clean_tracking();
    for (int i = 0; i < 3; i++) begin
      wait_gen(-1, HS);
      step(2);
      total++;
      if (bus.col !== COL_W'(HS)) begin
        bad++;
        $display("[TB] FAIL hsync_to_col[%0d]: got %0d want %0d", i, bus.col, HS);
      end
    end
    fs_pulses = 0;
    active_cycles = 0;
    track_n = 0;
    track_bad = 0;
    track_en = 1'b1;
    step(2*FRAME);
    track_en = 1'b0;
    total++;
    if (fs_pulses !== 2) begin
      bad++;
      $display("[TB] FAIL frame_start_count: got %0d want 2", fs_pulses);
    end
    total++;
    if (fs_last - fs_prev !== FRAME) begin
      bad++;
      $display("[TB] FAIL frame_start_period: got %0d want %0d", fs_last - fs_prev, FRAME);
    end
    total++;
    if (active_cycles !== 2*AR*AC) begin
      bad++;
      $display("[TB] FAIL active_span: got %0d want %0d", active_cycles, 2*AR*AC);
    end
    total++;
    if (track_n !== 2*FRAME || track_bad !== 0) begin
      bad++;
      $display("[TB] FAIL position_track: checked %0d (want %0d) wrong %0d (want 0)",
               track_n, 2*FRAME, track_bad);
    end
  endtask

  task automatic test_vsync_wrap();
    err_pulses = 0;
    wait_gen(VS, 1);
    total++;
    if (bus.row !== ROW_W'(VS-1) || bus.col !== COL_W'(TC-1)) begin
      bad++;
      $display("[TB] FAIL pre_wrap_pos: got %0d,%0d want %0d,%0d", bus.row, bus.col, VS-1, TC-1);
    end
    step(1);
    total++;
    if (bus.row !== ROW_W'(VS) || bus.col !== '0) begin
      bad++;
      $display("[TB] FAIL vsync_wrap_pos: got %0d,%0d want %0d,0", bus.row, bus.col, VS);
    end
    total++;
    if (bus.locked !== 1'b1 || err_pulses !== 0) begin
      bad++;
      $display("[TB] FAIL vsync_wrap_err: locked=%b errs=%0d want 1 0", bus.locked, err_pulses);
    end
  endtask

  task automatic test_drop_and_watchdog();
    err_pulses = 0;
    wait_gen(2, 0);
    drop_row = 3;
    wait_gen(4, 0);
    drop_row = -1;
    wait_gen(5, HS + 3);
    total++;
    if (bus.locked !== 1'b1 || err_pulses !== 0) begin
      bad++;
      $display("[TB] FAIL drop_one_hsync: locked=%b errs=%0d want 1 0", bus.locked, err_pulses);
    end
    wait_gen(6, 0);
    hold_h = 1'b1;
    step(2*TC);
    hold_h = 1'b0;
    total++;
    if (bus.locked !== 1'b0 || dut.state !== SEARCH) begin
      bad++;
      $display("[TB] FAIL watchdog: locked=%b state=%0d want 0 %0d", bus.locked, dut.state, SEARCH);
    end
    total++;
    if (err_pulses !== 0) begin
      bad++;
      $display("[TB] FAIL watchdog_err: got %0d pulses want 0", err_pulses);
    end
  endtask

  task automatic test_shift();
    int t_err, t_lock;
    wait_lock(4*FRAME, t_lock);
    total++;
    if (t_lock < 0) begin
      bad++;
      $display("[TB] FAIL relock_after_search: got timeout want lock");
    end
    wait_gen(2, 0);
    err_pulses = 0;
    shift_row = 3;
    wait_gen(3, HS + 5);
    t_err = cyc;
    total++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0) begin
      bad++;
      $display("[TB] FAIL shift_err: sync_err=%b locked=%b want 1 0", bus.sync_err, bus.locked);
    end
    total++;
    if (bus.col !== COL_W'(HS)) begin
      bad++;
      $display("[TB] FAIL shift_reload: got col %0d want %0d", bus.col, HS);
    end
    wait_gen(4, 0);
    shift_row = -1;
    wait_lock(3*FRAME, t_lock);
    total++;
    if (t_lock - t_err !== (VS-3)*TC - (HS+5) + FRAME + 2) begin
      bad++;
      $display("[TB] FAIL shift_relock_time: got %0d want %0d",
               (t_lock < 0) ? -1 : t_lock - t_err, (VS-3)*TC - (HS+5) + FRAME + 2);
    end
    total++;
    if (err_pulses !== 1) begin
      bad++;
      $display("[TB] FAIL shift_err_count: got %0d want 1", err_pulses);
    end
  endtask

  task automatic test_mid_reset();
    int t_lock;
    wait_gen(10, 20);
    total++;
    if (bus.row !== ROW_W'(10) || bus.locked !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset: row=%0d locked=%b want 10 1", bus.row, bus.locked);
    end
    RESET = 1'b0;
    #1;
    total++;
    if (bus.row !== '0 || bus.col !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset_pos: got %0d,%0d want 0,0", bus.row, bus.col);
    end
    total++;
    if ({bus.active, bus.locked, bus.frame_start, bus.sync_err} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL async_reset_flags: got %b want 0000",
               {bus.active, bus.locked, bus.frame_start, bus.sync_err});
    end
    step(3);
    unlocked_active = 0;
    RESET = 1'b1;
    wait_lock(4*FRAME, t_lock);
    total++;
    if (t_lock < 0) begin
      bad++;
      $display("[TB] FAIL relock_after_reset: got timeout want lock");
    end
    total++;
    if (unlocked_active !== 0) begin
      bad++;
      $display("[TB] FAIL active_during_reacquire: got %0d cycles want 0", unlocked_active);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_clean_tracking();
    test_vsync_wrap();
    test_drop_and_watchdog();
    test_shift();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/sync_to_count.md
# sync_to_count

Receive-side counterpart of the VGA sync pulse generator. Takes an HSync/VSync pair produced by a generator with the standard 640x480 timing and rebuilds the row and column counters from those pulses. Checks every sync edge against its own free-running prediction and reports lock. It sits in front of any pixel-processing stage fed only by sync signals, and in the bench it serves as a self-check on the generator.

## Interface
- TOTAL_COLS, 800, pixels per line
- ACTIVE_COLS, 640, visible pixels per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_ROWS, 480, visible lines per frame
- H_SYNC_START, 656, generator column at which hsync first asserts
- V_SYNC_START, 490, generator row at which vsync first asserts
- SYNC_ACTIVE, 1'b0, asserted level of both syncs
- LOCK_FRAMES, 2, consecutive clean frames needed to lock
- clk  input  1  pixel clock, same domain as the generator
- RESET  input  1  asynchronous, active-low reset
- hsync  input  1  horizontal sync from the generator
- vsync  input  1  vertical sync from the generator
- row  output  $clog2(TOTAL_ROWS)  reconstructed row
- col  output  $clog2(TOTAL_COLS)  reconstructed column
- active  output  1  locked && row<ACTIVE_ROWS && col<ACTIVE_COLS
- locked  output  1  FSM in LOCKED
- frame_start  output  1  one-cycle pulse at row==0 && col==0 while locked
- sync_err  output  1  one-cycle pulse on an edge mismatch while locked

## Operation
- Input stage:
  - s1 registers hsync/vsync; s2 registers s1.
  - Assertion edge = s1==SYNC_ACTIVE && s2!=SYNC_ACTIVE.
- Counters:
  - col free-runs and wraps TOTAL_COLS-1 -> 0.
  - row increments on col wrap and wraps TOTAL_ROWS-1 -> 0.
  - Predicted value = next value with no load applied.
- hsync edge: col <= H_SYNC_START. h_match = (predicted col == H_SYNC_START).
- vsync edge: row <= V_SYNC_START. v_match = (predicted row == V_SYNC_START).
  - A vsync load overrides a same-cycle row increment.
- FSM states SEARCH, ACQUIRE, LOCKED:
  - SEARCH: loads still apply. The first vsync edge seen after at least one hsync edge -> ACQUIRE, clean-frame count = 0.
  - ACQUIRE:
    - Any edge with a mismatch clears the count and stays in ACQUIRE.
    - A matching vsync edge increments the count.
    - When the count reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: any mismatch pulses sync_err, goes to ACQUIRE and clears the count.
  - Any state: no hsync edge for 2*TOTAL_COLS cycles -> SEARCH. A watchdog counter is cleared on each hsync edge.
- Gating: active and frame_start are forced to 0 unless in LOCKED. row and col are always driven.
- Reset: row=0, col=0, s1=s2=~SYNC_ACTIVE, FSM=SEARCH. All outputs are 0.
- Reset mid-frame: full re-acquire from SEARCH.

## Timing
- When locked, row/col equal the generator's counters delayed by exactly 2 clocks.
- A generator hsync asserted at its col 656 in cycle k gives col==656 at cycle k+2.
- locked and sync_err are registered. They change the cycle after the decisive edge is detected, i.e. the cycle in which the corresponding load takes effect.
- Simultaneous h and v mismatch gives a single sync_err pulse.
- A sync held asserted produces no further edges. The watchdog still applies.
- Lock time after reset from a clean source: at most LOCK_FRAMES+1 frames plus 2 cycles.

## Structure
- Shared package vga_pkg holds:
  - the timing constants (TOTAL/ACTIVE/SYNC_START values);
  - the state enum typedef (SEARCH, ACQUIRE, LOCKED).
- One sub-module, sync_edge_detect: s1/s2 registers plus the assertion-edge output, parameterised by SYNC_ACTIVE. It is instantiated twice, once for hsync and once for vsync.

## Test plan
- Clean source from reset:
  - locked rises after exactly 2 matching vsync edges post-SEARCH.
  - Then col==656 two cycles after each hsync assertion.
  - frame_start fires once per 420000 cycles.
- Drop one hsync pulse while locked:
  - No mismatch, because the prediction still holds, so locked stays 1.
  - Then hold hsync deasserted for 1600 cycles -> locked=0, FSM=SEARCH.
- Shift one hsync pulse by +3 cycles while locked:
  - sync_err pulses once and locked goes to 0.
  - col reloads to 656.
  - locked returns after 2 clean frames.
- vsync edge on the same cycle as a col wrap at row 489: row==490, not 490+1, and no error.
- Assert RESET low mid-line at row 200: all outputs 0 immediately (asynchronous). After release, active stays 0 until re-lock.
- Verify active exactly spans 640x480 per frame while locked: 307200 active cycles per frame.
